id_ex_stage: RTL and testbench

- Pipeline register between decode (register-file read) and execute in the pipelined RV32I core.
- Captures RD1/RD2, immediate, destination index and control bits each cycle.
- Detects load-use hazards and stalls upstream for one cycle, inserting a bubble.
- Honours branch flush and bypasses same-cycle writeback data onto operands.

---
 rtl/id_ex_stage.sv | 106 ++++++++++
 tb/tb_id_ex_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: load-use stall, branch flush, writeback bypass.
// Optional IDEX_PERF_CNT_EN adds stall/flush event counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              ex_flush,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
`ifdef IDEX_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic            ld_in_ex;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            wb_fwd;
    logic [XLEN-1:0] op1_nxt;
    logic [XLEN-1:0] op2_nxt;

    // Load in EX whose destination a valid ID instruction reads; flush kills it.
    assign ld_in_ex = ex_valid & ex_ctrl[1] & (ex_rd != '0);
    assign rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
    assign stall_o  = id_valid & ld_in_ex & (rs1_hit | rs2_hit) & ~ex_flush;

    // Same-cycle writeback beats the stale regfile read; x0 is never forwarded.
    assign wb_fwd  = wb_we & (wb_rd != '0);
    assign op1_nxt = (wb_fwd && wb_rd == id_rs1) ? wb_wd : id_rd1;
    assign op2_nxt = (wb_fwd && wb_rd == id_rs2) ? wb_wd : id_rd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
            ex_ctrl  <= '0;
        end else if (ex_flush || stall_o) begin
            ex_valid <= 1'b0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            ex_op1   <= op1_nxt;
            ex_op2   <= op2_nxt;
            ex_imm   <= id_imm;
            ex_pc    <= id_pc;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    // stall_o is already low on flush cycles, so each cycle lands in one counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_o)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (ex_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios, then randomized traffic
// against a behavioural model of the EX slot.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, wb_we, ex_flush;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc, wb_wd;
    logic [7:0]  id_ctrl;
    logic        stall_o, ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
    logic [7:0]  ex_ctrl;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .ex_flush(ex_flush), .stall_o(stall_o),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_pc(ex_pc),
`ifdef IDEX_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] op1, op2, imm, pc;
        logic [7:0]  ctrl;
    } ex_t;

    ex_t         m;
    logic        m_bubble;
    int          passed = 0;
    int          total  = 0;
    int unsigned m_stall_cnt = 0;
    int unsigned m_flush_cnt = 0;
    int          n_stalls = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: a load occupying EX blocks any valid ID instruction that reads its rd.
    function automatic logic model_stall();
        logic dep;
        dep = (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
        return id_valid && m.v && m.ctrl[1] && m.rd != 0 && dep && !ex_flush;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        return (wb_we && wb_rd != 0 && wb_rd == rs) ? wb_wd : rf;
    endfunction

    task automatic check_ex(input string tag);
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.v});
        chk({tag, ".ctrl"}, {24'd0, ex_ctrl}, {24'd0, m.ctrl});
        if (!m_bubble) begin
            chk({tag, ".rs1"}, {27'd0, ex_rs1}, {27'd0, m.rs1});
            chk({tag, ".rs2"}, {27'd0, ex_rs2}, {27'd0, m.rs2});
            chk({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, m.rd});
            chk({tag, ".op1"}, ex_op1, m.op1);
            chk({tag, ".op2"}, ex_op2, m.op2);
            chk({tag, ".imm"}, ex_imm, m.imm);
            chk({tag, ".pc"}, ex_pc, m.pc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"}, {31'd0, stall_o}, 32'd0);
        m = '0;
        m_bubble = 1'b0;
        check_ex(tag);
    endtask

    // Called in the low clock phase with ID/WB inputs already driven.
    task automatic cycle(input string tag, output logic s);
        #1;
        s = model_stall();
        chk({tag, ".stall_o"}, {31'd0, stall_o}, {31'd0, s});
        if (ex_flush) begin
            m = '0; m_bubble = 1'b0; m_flush_cnt++;
        end else if (s) begin
            m.v = 1'b0; m.ctrl = '0; m_bubble = 1'b1; m_stall_cnt++;
        end else begin
            m.v = id_valid; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.op1 = fwd(id_rs1, id_rd1); m.op2 = fwd(id_rs2, id_rd2);
            m.imm = id_imm; m.pc = id_pc; m.ctrl = id_valid ? id_ctrl : 8'h00;
            m_bubble = 1'b0;
        end
        @(posedge clk);
        #1;
        check_ex(tag);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [7:0] c);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_rd1 = d1; id_rd2 = d2; id_ctrl = c;
        id_imm = $urandom; id_pc = $urandom & 32'hFFFF_FFFC;
    endtask

    initial begin
        logic s;
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_we = 0; wb_rd = 0; wb_wd = 0; ex_flush = 0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain capture.
        set_id(1, 3, 4, 1, 1, 9, 32'h11, 32'h22, 8'h01);
        cycle("normal", s);
        chk("normal.op1_lit", ex_op1, 32'h11);
        chk("normal.op2_lit", ex_op2, 32'h22);

        // Load-use: lw x5 then add reading x5, re-presented after the bubble.
        set_id(1, 1, 2, 1, 0, 5, 32'h100, 32'h0, 8'h03);
        cycle("lw", s);
        set_id(1, 5, 6, 1, 1, 6, 32'hAA, 32'hBB, 8'h01);
        cycle("loaduse", s);
        chk("loaduse.stalled", {31'd0, s}, 32'd1);
        cycle("loaduse_retry", s);
        chk("loaduse_retry.valid_lit", {31'd0, ex_valid}, 32'd1);

        // Flush outranks the same hazard.
        set_id(1, 1, 2, 1, 0, 5, 32'h100, 32'h0, 8'h03);
        cycle("lw2", s);
        set_id(1, 5, 6, 1, 1, 6, 32'hAA, 32'hBB, 8'h01);
        ex_flush = 1;
        cycle("flush", s);
        ex_flush = 0;

        // Writeback bypass onto op2, and x0 never bypassed.
        set_id(1, 1, 7, 1, 1, 8, 32'h1, 32'h7, 8'h01);
        wb_we = 1; wb_rd = 7; wb_wd = 32'hDEADBEEF;
        cycle("bypass", s);
        chk("bypass.op2_lit", ex_op2, 32'hDEADBEEF);
        set_id(1, 1, 0, 1, 1, 8, 32'h1, 32'h55, 8'h01);
        wb_rd = 0;
        cycle("bypass_x0", s);
        chk("bypass_x0.op2_lit", ex_op2, 32'h55);
        wb_we = 0;

        // Random traffic; a stalled instruction is re-presented unchanged.
        s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!s)
                set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                       $urandom, $urandom, 8'($urandom));
            wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_wd = $urandom;
            ex_flush = $urandom_range(0, 9) == 0;
            cycle("rand", s);
            if (s) n_stalls++;
        end
        ex_flush = 0; wb_we = 0;
        chk("rand.saw_stalls", {31'd0, n_stalls > 5}, 32'd1);

`ifdef IDEX_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
        chk("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif

        // Reset in the middle of a stall cycle.
        set_id(1, 1, 2, 1, 0, 5, 32'h100, 32'h0, 8'h03);
        cycle("lw3", s);
        set_id(1, 0, 5, 0, 1, 6, 32'hAA, 32'hBB, 8'h01);
        #1;
        chk("prereset.stall_o", {31'd0, stall_o}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
`ifdef IDEX_PERF_CNT_EN
        chk("midreset.perf_stall", perf_stall_cnt, 32'd0);
        chk("midreset.perf_flush", perf_flush_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
